// File: rtl/dr_token_arbiter.sv
// Round-robin front-end that shares one dual-rail asynchronous pipeline input between
// two synchronous requesters and runs a four-phase return-to-zero handshake per token.
module dr_token_arbiter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic [WIDTH-1:0]   data0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   data1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] dr_out,
    input  logic               ack_in,
    output logic               busy,
    output logic               err,
    output logic [1:0]         fsm_state
);
    // Requester handshake: req_x is held with data_x stable until done_x. gnt_x rises on
    // the cycle the codeword appears on dr_out and stays high until the single-cycle
    // done_x pulse, which marks the spacer as returned. A new grant may issue during done_x.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] SYNC_FILL = CW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        DATA   = 2'd2,
        SPACER = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   rr_last, rr_last_next;
    logic                   gnt0_next, gnt1_next, done0_next, done1_next;
    logic [2*WIDTH-1:0]     dr_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   err_next;

    function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            rr_last <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            dr_out  <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            rr_last <= rr_last_next;
            gnt0    <= gnt0_next;
            gnt1    <= gnt1_next;
            done0   <= done0_next;
            done1   <= done1_next;
            dr_out  <= dr_next;
            cnt     <= cnt_next;
            err     <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_last_next = rr_last;
        gnt0_next    = gnt0;
        gnt1_next    = gnt1;
        done0_next   = 1'b0;
        done1_next   = 1'b0;
        dr_next      = dr_out;
        case (state)
            INIT: begin
                // The synchronizer resets to 0, so ack_s only reflects ack_in once it has filled.
                if (!ack_s && cnt >= SYNC_FILL) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (req0 && (!req1 || rr_last)) begin
                    gnt0_next    = 1'b1;
                    dr_next      = encode(data0);
                    rr_last_next = 1'b0;
                    state_next   = DATA;
                end else if (req1) begin
                    gnt1_next    = 1'b1;
                    dr_next      = encode(data1);
                    rr_last_next = 1'b1;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (ack_s) begin
                    dr_next    = '0;
                    state_next = SPACER;
                end
            end
            SPACER: begin
                if (!ack_s) begin
                    done0_next = gnt0;
                    done1_next = gnt1;
                    gnt0_next  = 1'b0;
                    gnt1_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase

        // A stalled phase is only flagged; the handshake cannot be withdrawn once started.
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == IDLE || cnt == CNT_MAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + 1'b1;
        end
        err_next = err | (cnt_next == CNT_MAX);
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_dr_token_arbiter.sv
// Directed bench for dr_token_arbiter: token-level reference model checked every cycle,
// plus hand-computed codewords, orderings and timeout latencies.
module tb_dr_token_arbiter;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int TO = 16;

    localparam int PH_DRAIN  = 0;
    localparam int PH_FREE   = 1;
    localparam int PH_WORD   = 2;
    localparam int PH_RETURN = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   data0 = '0, data1 = '0;
    logic           ack_in = 1'b1;
    logic           gnt0, gnt1, done0, done1, busy, err;
    logic [2*W-1:0] dr_out;
    logic [1:0]     fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_cmp  = 1'b1;
    int ack_mode = 3;  // 0 follow dr_out after 3 cycles, 1 force low, 2 force high, 3 manual
    logic [2:0] ack_hist = '0;

    // Reference model state (token level)
    int          m_phase = PH_DRAIN;
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_done  = -1;
    int          m_dwell = 0;
    int          m_since = 0;
    bit          m_err   = 1'b0;
    logic [W-1:0] m_word = '0;
    logic [SS-1:0] m_sync = '0;

    dr_token_arbiter #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .dr_out(dr_out), .ack_in(ack_in), .busy(busy), .err(err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [2*W+5:0] model_vec();
        logic [2*W-1:0] d;
        d = (m_phase == PH_WORD) ? enc(m_word) : '0;
        return {d, m_owner == 0, m_owner == 1, m_done == 0, m_done == 1,
                m_phase != PH_FREE, m_err};
    endfunction

    task automatic model_reset();
        m_phase = PH_DRAIN; m_owner = -1; m_last = 1; m_done = -1;
        m_dwell = 0; m_since = 0; m_err = 1'b0; m_sync = '0;
    endtask

    task automatic model_step();
        bit a_s;
        bit moved;
        int who;
        a_s   = m_sync[SS-1];
        moved = 1'b0;
        who   = -1;
        m_done = -1;
        case (m_phase)
            PH_DRAIN: if (!a_s && m_since >= SS) begin m_phase = PH_FREE; moved = 1'b1; end
            PH_FREE: begin
                if (req0 && req1) who = 1 - m_last;
                else if (req0)    who = 0;
                else if (req1)    who = 1;
                if (who >= 0) begin
                    m_owner = who; m_last = who;
                    m_word  = (who == 1) ? data1 : data0;
                    m_phase = PH_WORD; moved = 1'b1;
                end
            end
            PH_WORD: if (a_s) begin m_phase = PH_RETURN; moved = 1'b1; end
            default: if (!a_s) begin
                m_done = m_owner; m_owner = -1; m_phase = PH_FREE; moved = 1'b1;
            end
        endcase
        if (moved) m_dwell = 0;
        else if (m_phase != PH_FREE) begin
            m_dwell++;
            if (m_dwell >= TO) begin m_dwell = TO; m_err = 1'b1; end
        end
        if (m_since < 1000) m_since++;
        m_sync = {m_sync[SS-2:0], ack_in};
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model (or reset values while rst_n is low)
    initial forever begin
        logic [2*W+5:0] exp_v;
        @(negedge clk);
        if (run_cmp) begin
            if (!rst_n) exp_v = {{(2*W){1'b0}}, 6'b000010};
            else exp_v = model_vec();
            check("cycle", {dr_out, gnt0, gnt1, done0, done1, busy, err}, exp_v);
            check("gnt_excl", gnt0 & gnt1, 0);
        end
    end

    // First-stage acknowledge model
    initial forever begin
        @(posedge clk);
        #1;
        ack_hist = {ack_hist[1:0], dr_out != '0};
        case (ack_mode)
            0: ack_in = ack_hist[2];
            1: ack_in = 1'b0;
            2: ack_in = 1'b1;
            default: ;
        endcase
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0: return gnt0;
            1: return gnt1;
            2: return done0;
            3: return done1;
            4: return busy;
            5: return gnt0 | gnt1;
            default: return dr_out == '0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input bit val, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (sig(sel) == val) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    task automatic reset_quiet();
        ack_mode = 0;
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        wait_sig(4, 1'b0, 20, "rst_idle");
    endtask

    initial begin
        int cnt;
        logic [3:0] ord;

        // Reset with the downstream stage still holding a token
        ack_in = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(busy); end
        check("t1_init_busy", cnt, 10);
        check("t1_init_gnt", gnt0 | gnt1, 0);
        step();
        ack_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_busy_2cyc", busy, 1);
        @(negedge clk);
        check("t1_idle", busy, 0);

        // Single token from requester 0
        ack_mode = 0;
        step();
        req0 = 1'b1; data0 = 4'b1010;
        wait_sig(5, 1'b1, 10, "t2_gnt");
        check("t2_code", dr_out, 8'b10011001);
        check("t2_gnt0", gnt0, 1);
        wait_sig(6, 1'b1, 30, "t2_spacer");
        check("t2_gnt_hold", gnt0, 1);
        wait_sig(2, 1'b1, 30, "t2_done");
        check("t2_gnt_low", gnt0, 0);
        req0 = 1'b0;
        cnt = 0;
        repeat (8) begin @(negedge clk); cnt += int'(done0 | gnt0); end
        check("t2_single_done", cnt, 0);

        // Both requesting from reset: strict alternation starting with requester 0
        reset_quiet();
        data0 = 4'b1010; data1 = 4'b0001;
        req0 = 1'b1; req1 = 1'b1;
        ord = '0;
        for (int k = 0; k < 4; k++) begin
            wait_sig(5, 1'b1, 40, "t3_gnt");
            ord[k] = gnt1;
            if (k == 1) check("t3_code1", dr_out, 8'b01010110);
            wait_sig(5, 1'b0, 60, "t3_release");
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t3_order", ord, 4'b1010);

        // Acknowledge stuck low in DATA
        reset_quiet();
        ack_mode = 1;
        step();
        req0 = 1'b1; data0 = 4'b0110;
        wait_sig(0, 1'b1, 10, "t4_gnt");
        repeat (15) @(negedge clk);
        check("t4_err_before", err, 0);
        @(negedge clk);
        check("t4_err_at", err, 1);
        check("t4_code_held", dr_out, 8'b01101001);
        ack_mode = 0;
        wait_sig(2, 1'b1, 40, "t4_done");
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_err_sticky", err, 1);

        // Reset during SPACER, downstream still holding the token
        reset_quiet();
        req0 = 1'b1; data0 = 4'b1111;
        wait_sig(0, 1'b1, 10, "t5_gnt");
        wait_sig(6, 1'b1, 30, "t5_spacer");
        check("t5_pre_gnt", gnt0, 1);
        #1;
        ack_mode = 2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_dr", dr_out, 0);
        check("t5_rst_gnt", gnt0, 0);
        check("t5_rst_busy", busy, 1);
        step();
        step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin @(negedge clk); cnt += int'(gnt0); end
        check("t5_init_nogrant", cnt, 0);
        ack_mode = 0;
        wait_sig(0, 1'b1, 20, "t5_regrant");
        check("t5_code", dr_out, 8'b10101010);
        wait_sig(2, 1'b1, 40, "t5_done");
        req0 = 1'b0;

        // Requester 1 drops req mid-handshake
        step();
        req1 = 1'b1; data1 = 4'b1001;
        wait_sig(1, 1'b1, 10, "t6_gnt");
        check("t6_code", dr_out, 8'b10010110);
        @(negedge clk);
        req1 = 1'b0;
        wait_sig(3, 1'b1, 40, "t6_done");
        check("t6_gnt_low", gnt1, 0);
        cnt = 0;
        repeat (6) begin @(negedge clk); cnt += int'(gnt0 | gnt1 | done1); end
        check("t6_quiet", cnt, 0);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
